// File: rtl/seq_memory_checker.sv
// Sequence RAM plus round controller for the memory game: grows the symbol sequence by one
// LFSR sample per round, replays it with timed on/gap slots, then checks the player's entries.
module seq_memory_checker #(
    parameter int MAX_LEN       = 16,
    parameter int SHOW_TICKS    = 500,
    parameter int GAP_TICKS     = 250,
    parameter int INPUT_TIMEOUT = 0,
    localparam int LW           = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    rnd,
    input  logic          start,
    input  logic          btn_valid,
    input  logic [1:0]    btn,
    output logic          show_valid,
    output logic [1:0]    show_sym,
    output logic          busy,
    output logic [LW-1:0] level,
    output logic          win,
    output logic          fail
);

    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int MAXT0 = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int MAXT  = (MAXT0 > INPUT_TIMEOUT) ? MAXT0 : INPUT_TIMEOUT;
    localparam int TW    = $clog2(MAXT + 1);

    typedef enum logic [2:0] {
        IDLE,
        APPEND,
        SHOW_ON,
        SHOW_GAP,
        WAIT_IN,
        WIN,
        FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [1:0]    mem [MAX_LEN];
    logic [1:0]    cur_sym;
    logic          last_idx;

    // idx never reaches MAX_LEN, so the low address bits are enough to index the RAM
    assign cur_sym  = mem[idx_q[AW-1:0]];
    assign last_idx = (idx_q == len_q - LW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == APPEND) begin
            mem[len_q[AW-1:0]] <= rnd;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        case (state_q)
            IDLE, WIN, FAIL: begin
                if (start) begin
                    state_d = APPEND;
                    len_d   = '0;
                end
            end
            APPEND: begin
                len_d   = len_q + LW'(1);
                idx_d   = '0;
                timer_d = '0;
                state_d = SHOW_ON;
            end
            SHOW_ON: begin
                if (timer_q == TW'(SHOW_TICKS - 1)) begin
                    state_d = SHOW_GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            SHOW_GAP: begin
                if (timer_q == TW'(GAP_TICKS - 1)) begin
                    timer_d = '0;
                    if (last_idx) begin
                        state_d = WAIT_IN;
                        idx_d   = '0;
                    end else begin
                        state_d = SHOW_ON;
                        idx_d   = idx_q + LW'(1);
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_IN: begin
                // an entry always takes priority over the timeout and over a stray start
                if (btn_valid) begin
                    timer_d = '0;
                    if (btn != cur_sym) begin
                        state_d = FAIL;
                    end else if (last_idx) begin
                        state_d = (len_q == LW'(MAX_LEN)) ? WIN : APPEND;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end else if (INPUT_TIMEOUT > 0) begin
                    if (timer_q == TW'(INPUT_TIMEOUT - 1)) begin
                        state_d = FAIL;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign show_valid = (state_q == SHOW_ON);
    assign show_sym   = (state_q == SHOW_ON) ? cur_sym : 2'b00;
    assign busy       = (state_q == APPEND) || (state_q == SHOW_ON) ||
                        (state_q == SHOW_GAP) || (state_q == WAIT_IN);
    assign level      = len_q;
    assign win        = (state_q == WIN);
    assign fail       = (state_q == FAIL);

endmodule
